// File: rtl/effect_pkg.sv
// Shared state encoding, gain limits and index-wrap helper for the effect sequencer.
package effect_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } state_e;

   localparam logic [7:0] GAIN_MAX = 8'd255;
   localparam logic [7:0] GAIN_MIN = 8'd0;

   // Step an effect index forward or backward, wrapping between 0 and last.
   function automatic logic [2:0] step_index(input logic [2:0] idx,
                                             input logic       fwd,
                                             input logic [2:0] last);
      if (fwd) return (idx == last) ? 3'd0 : idx + 3'd1;
      else     return (idx == 3'd0) ? last : idx - 3'd1;
   endfunction

endpackage

// File: rtl/effect_sequencer_edge_detect.sv
// Rising-edge detector for one debounced button level.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   // Flop remembers that the button was seen low; cleared by reset so a
   // level already high at reset release must drop before it can fire.
   logic seen_low_q;
   logic seen_low_d;

   always_comb begin
      seen_low_d = ~btn;
      pulse      = btn & seen_low_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_low_q <= 1'b0;
      else        seen_low_q <= seen_low_d;
   end

endmodule

// File: rtl/effect_sequencer.sv
// Effect selection sequencer: cross-fades the wet-path gain around every
// effect change and adjusts the effect parameter while idle.
module effect_sequencer
   import effect_pkg::*;
#(
   parameter int unsigned N_EFFECTS     = 4,
   parameter int unsigned RAMP_STEP     = 8,
   parameter int unsigned PARAM_STEP    = 16,
   parameter int unsigned PARAM_DEFAULT = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [2:0] effect_sel,
   output logic [7:0] param,
   output logic [7:0] gain,
   output logic       busy
);

   localparam logic [2:0] LAST_IDX  = 3'(N_EFFECTS - 1);
   localparam logic [7:0] PARAM_RST = 8'(PARAM_DEFAULT);
   localparam logic [8:0] RAMP_9    = 9'(RAMP_STEP);
   localparam logic [8:0] PSTEP_9   = 9'(PARAM_STEP);

   logic ev_next, ev_prev, ev_up, ev_down;

   edge_detect u_ed_next (.clk(clk), .rst_n(rst_n), .btn(btn_next), .pulse(ev_next));
   edge_detect u_ed_prev (.clk(clk), .rst_n(rst_n), .btn(btn_prev), .pulse(ev_prev));
   edge_detect u_ed_up   (.clk(clk), .rst_n(rst_n), .btn(btn_up),   .pulse(ev_up));
   edge_detect u_ed_down (.clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(ev_down));

   state_e     state_q, state_d;
   logic [7:0] gain_q, gain_d;
   logic [7:0] param_q, param_d;
   logic [2:0] effect_sel_q, effect_sel_d;
   logic [2:0] pending_q, pending_d;
   logic       busy_q, busy_d;

   logic       move, adjust;
   logic [8:0] gain_up_sum, param_up_sum;
   logic [7:0] gain_up_sat, gain_dn_sat, param_up_sat, param_dn_sat;

   always_comb begin
      // Exactly one of a pair must fire; simultaneous presses cancel.
      move         = ev_next ^ ev_prev;
      adjust       = ev_up ^ ev_down;
      gain_up_sum  = {1'b0, gain_q} + RAMP_9;
      param_up_sum = {1'b0, param_q} + PSTEP_9;
      gain_up_sat  = (gain_up_sum > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up_sum[7:0];
      gain_dn_sat  = ({1'b0, gain_q} <= RAMP_9) ? GAIN_MIN : gain_q - RAMP_9[7:0];
      param_up_sat = param_up_sum[8] ? 8'd255 : param_up_sum[7:0];
      param_dn_sat = ({1'b0, param_q} <= PSTEP_9) ? 8'd0 : param_q - PSTEP_9[7:0];
   end

   always_comb begin
      state_d      = state_q;
      gain_d       = gain_q;
      param_d      = param_q;
      effect_sel_d = effect_sel_q;
      pending_d    = pending_q;
      case (state_q)
         IDLE: begin
            gain_d = GAIN_MAX;
            if (move) begin
               pending_d = step_index(effect_sel_q, ev_next, LAST_IDX);
               state_d   = FADE_OUT;
            end else if (adjust) begin
               param_d = ev_up ? param_up_sat : param_dn_sat;
            end
         end
         FADE_OUT: begin
            if (move) pending_d = step_index(pending_q, ev_next, LAST_IDX);
            if (gain_q == GAIN_MIN) state_d = SWAP;
            else if (sample_en)     gain_d  = gain_dn_sat;
         end
         SWAP: begin
            effect_sel_d = pending_q;
            param_d      = PARAM_RST;
            state_d      = FADE_IN;
         end
         FADE_IN: begin
            // A new request reverses the ramp from wherever the gain is now.
            if (move) begin
               pending_d = step_index(effect_sel_q, ev_next, LAST_IDX);
               state_d   = FADE_OUT;
            end else if (gain_q == GAIN_MAX) begin
               state_d = IDLE;
            end else if (sample_en) begin
               gain_d = gain_up_sat;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gain_q       <= GAIN_MAX;
         param_q      <= PARAM_RST;
         effect_sel_q <= '0;
         pending_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gain_q       <= gain_d;
         param_q      <= param_d;
         effect_sel_q <= effect_sel_d;
         pending_q    <= pending_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      effect_sel = effect_sel_q;
      param      = param_q;
      gain       = gain_q;
      busy       = busy_q;
   end

endmodule

// File: tb/tb_effect_sequencer.sv
// Self-checking bench: directed scenarios plus random buttons/sample ticks,
// compared every cycle against a behavioural model of the sequencer.
module tb_effect_sequencer;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       sample_en = 1'b0;
   logic       btn_next = 1'b0, btn_prev = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [2:0] effect_sel;
   logic [7:0] param, gain;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          chk_en = 1'b0;
   bit          se_rand = 1'b0;
   int          zero_hits = 0;
   int          prev_gain = 255;

   always #5 clk = ~clk;

   effect_sequencer #(
      .N_EFFECTS(4), .RAMP_STEP(8), .PARAM_STEP(16), .PARAM_DEFAULT(128)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
      .btn_next(btn_next), .btn_prev(btn_prev), .btn_up(btn_up), .btn_down(btn_down),
      .effect_sel(effect_sel), .param(param), .gain(gain), .busy(busy)
   );

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model. mode: 0 steady, 1 fading down, 2 switching, 3 fading up.
   int m_mode = 0, m_sel = 0, m_param = 128, m_gain = 255, m_pend = 0;
   bit m_armed [4] = '{default: 1'b0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_sel = 0; m_param = 128; m_gain = 255; m_pend = 0;
         for (int i = 0; i < 4; i++) m_armed[i] = 1'b0;
      end else begin
         bit lv [4];
         bit ev [4];
         bit go_next, go_prev, go_up, go_down;
         lv[0] = btn_next; lv[1] = btn_prev; lv[2] = btn_up; lv[3] = btn_down;
         for (int i = 0; i < 4; i++) begin
            ev[i]      = lv[i] && m_armed[i];
            m_armed[i] = !lv[i];
         end
         go_next = ev[0] && !ev[1];
         go_prev = ev[1] && !ev[0];
         go_up   = ev[2] && !ev[3];
         go_down = ev[3] && !ev[2];
         case (m_mode)
            0: begin
               if (go_next || go_prev) begin
                  m_pend = go_next ? (m_sel + 1) % N : (m_sel + N - 1) % N;
                  m_mode = 1;
               end else if (go_up) begin
                  m_param = (m_param + 16 > 255) ? 255 : m_param + 16;
               end else if (go_down) begin
                  m_param = (m_param < 16) ? 0 : m_param - 16;
               end
            end
            1: begin
               if (go_next || go_prev)
                  m_pend = go_next ? (m_pend + 1) % N : (m_pend + N - 1) % N;
               if (m_gain == 0) m_mode = 2;
               else if (sample_en) m_gain = (m_gain < 8) ? 0 : m_gain - 8;
            end
            2: begin
               m_sel = m_pend; m_param = 128; m_mode = 3;
            end
            default: begin
               if (go_next || go_prev) begin
                  m_pend = go_next ? (m_sel + 1) % N : (m_sel + N - 1) % N;
                  m_mode = 1;
               end else if (m_gain == 255) m_mode = 0;
               else if (sample_en) m_gain = (m_gain + 8 > 255) ? 255 : m_gain + 8;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("effect_sel", effect_sel, m_sel);
         check_eq("param", param, m_param);
         check_eq("gain", gain, m_gain);
         check_eq("busy", busy, (m_mode != 0) ? 1 : 0);
      end
      if (gain == 0 && prev_gain != 0) zero_hits++;
      prev_gain = gain;
   end

   // Sample ticks: every 4th clk in directed scenarios, random otherwise.
   initial begin
      int unsigned se_cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (se_rand) sample_en = ($urandom_range(0, 2) == 0);
         else         sample_en = (se_cnt % 4 == 0);
         se_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_next = v;
         1: btn_prev = v;
         2: btn_up   = v;
         default: btn_down = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1); tick(2);
      set_btn(b, 1'b0); tick(2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tick(2);
      rst_n = 1'b1; tick(2);
   endtask

   task automatic wait_idle(input string tag);
      int cnt = 0;
      while (busy && cnt < 3000) begin tick(1); cnt++; end
      check_eq(tag, busy, 0);
   endtask

   task automatic wait_model(input string tag, input int mode, input int thr, input bit below);
      int cnt = 0;
      while (!(m_mode == mode && (below ? m_gain <= thr : m_gain >= thr)) && cnt < 3000) begin
         tick(1); cnt++;
      end
      check_eq(tag, (cnt < 3000) ? 1 : 0, 1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      tick(2);
      check_eq("rst_sel", effect_sel, 0);
      check_eq("rst_param", param, 128);
      check_eq("rst_gain", gain, 255);
      check_eq("rst_busy", busy, 0);
      rst_n = 1'b1; tick(2);

      // Basic next with full cross-fade.
      zero_hits = 0;
      press(0);
      check_eq("next_busy", busy, 1);
      wait_idle("next_idle");
      check_eq("next_sel", effect_sel, 1);
      check_eq("next_dips", zero_hits, 1);
      check_eq("next_gain", gain, 255);

      // Wrap both ways.
      do_reset();
      press(1); wait_idle("prev_idle");
      check_eq("wrap_prev_sel", effect_sel, 3);
      press(0); wait_idle("wrap_next_idle");
      check_eq("wrap_next_sel", effect_sel, 0);

      // Retarget during fade-out: single dip.
      zero_hits = 0;
      press(0);
      wait_model("wait_fo128", 1, 128, 1'b1);
      press(0); wait_idle("fo_retgt_idle");
      check_eq("fo_retgt_sel", effect_sel, 2);
      check_eq("fo_retgt_dips", zero_hits, 1);

      // Retarget during fade-in: ramps back down.
      do_reset();
      zero_hits = 0;
      press(0);
      wait_model("wait_fi64", 3, 64, 1'b0);
      press(0);
      check_eq("fi_retgt_busy", busy, 1);
      wait_idle("fi_retgt_idle");
      check_eq("fi_retgt_sel", effect_sel, 2);
      check_eq("fi_retgt_dips", zero_hits, 2);

      // Parameter saturation and simultaneous up/down.
      do_reset();
      repeat (9) press(2);
      check_eq("param_max", param, 255);
      repeat (17) press(3);
      check_eq("param_min", param, 0);
      press(2);
      check_eq("param_step", param, 16);
      btn_up = 1'b1; btn_down = 1'b1; tick(2);
      btn_up = 1'b0; btn_down = 1'b0; tick(2);
      check_eq("param_both", param, 16);
      check_eq("param_busy", busy, 0);

      // Reset mid-fade with btn_next held through reset.
      press(0);
      wait_model("wait_fo100", 1, 100, 1'b1);
      btn_next = 1'b1;
      rst_n = 1'b0; #1;
      check_eq("mid_rst_gain", gain, 255);
      check_eq("mid_rst_sel", effect_sel, 0);
      check_eq("mid_rst_busy", busy, 0);
      tick(3);
      rst_n = 1'b1;
      tick(40);
      check_eq("held_btn_busy", busy, 0);
      check_eq("held_btn_gain", gain, 255);
      btn_next = 1'b0; tick(2);

      // Random traffic, including occasional async resets.
      se_rand = 1'b1;
      for (int unsigned c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 11) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 11) == 0) btn_prev = ~btn_prev;
         if ($urandom_range(0, 9) == 0)  btn_up   = ~btn_up;
         if ($urandom_range(0, 9) == 0)  btn_down = ~btn_down;
         rst_n = ($urandom_range(0, 599) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      btn_next = 1'b0; btn_prev = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
